// File: rtl/debug_wr_arbiter_pkg.sv
// Shared definitions for the debug write arbiter: debug sink address map,
// the queued write record, and a helper that classifies safe-record writes.
package debug_wr_arbiter_pkg;

    localparam logic [23:0] DBG_ADDR_UART        = 24'h000000;
    localparam logic [23:0] DBG_ADDR_HALT        = 24'h000004;
    localparam logic [23:0] DBG_ADDR_TRAFFIC     = 24'h000008;
    localparam logic [23:0] DBG_ADDR_SCHED       = 24'h000010;
    localparam logic [23:0] DBG_ADDR_SAFE_SND    = 24'h000050;
    localparam logic [23:0] DBG_ADDR_SAFE_INF    = 24'h000054;
    localparam logic [23:0] DBG_ADDR_SAFE_EDGE   = 24'h000058;
    localparam logic [23:0] DBG_ADDR_SAFE_COMMIT = 24'h00005C;

    typedef struct packed {
        logic [23:0] addr;
        logic [31:0] data;
    } dbg_wr_t;

    // True for the body words of a safe record (the ones that open or extend a lock).
    function automatic logic is_safe_body_addr(input logic [23:0] addr);
        return (addr == DBG_ADDR_SAFE_SND) ||
               (addr == DBG_ADDR_SAFE_INF) ||
               (addr == DBG_ADDR_SAFE_EDGE);
    endfunction

endpackage

// File: rtl/debug_wr_arbiter_fifo.sv
// Per-requester queue of pending debug writes. Synchronous FIFO with
// full/empty flags; a push and a pop on the same edge leave the count unchanged.
module debug_wr_fifo
    import debug_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    push_i,
    input  dbg_wr_t wdata_i,
    input  logic    pop_i,
    output dbg_wr_t head_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    dbg_wr_t          mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the queue by clearing pointers and count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/debug_wr_arbiter.sv
// Round-robin arbiter sharing the single debug sink write port among NREQ
// requesters. Safe records (0x50/0x54/0x58 .. 0x5C) are issued atomically via
// a per-owner lock with an idle timeout; a halt write freezes all traffic.
module debug_wr_arbiter
    import debug_wr_arbiter_pkg::*;
#(
    parameter int          NREQ             = 2,
    parameter int          FIFO_DEPTH       = 4,
    parameter int          LOCK_TIMEOUT     = 256,
    parameter logic [23:0] HALT_ADDR        = DBG_ADDR_HALT,
    parameter logic [23:0] SAFE_COMMIT_ADDR = DBG_ADDR_SAFE_COMMIT,
    localparam int         OWNER_W          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NREQ-1:0]           req_valid_i,
    output logic [NREQ-1:0]           req_ready_o,
    input  logic [NREQ-1:0][23:0]     req_addr_i,
    input  logic [NREQ-1:0][31:0]     req_data_i,
    output logic                      dbg_en_o,
    output logic                      dbg_we_o,
    output logic [23:0]               dbg_addr_o,
    output logic [31:0]               dbg_data_o,
    output logic                      lock_active_o,
    output logic [OWNER_W-1:0]        lock_owner_o,
    output logic                      lock_timeout_o,
    output logic                      halted_o
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT) + 1;

    logic [NREQ-1:0] fifo_full;
    logic [NREQ-1:0] fifo_empty;
    logic [NREQ-1:0] push;
    logic [NREQ-1:0] pop;
    logic [NREQ-1:0] eligible;
    dbg_wr_t         fifo_head [NREQ];

    logic               gnt_valid;
    logic [OWNER_W-1:0] gnt_idx;
    dbg_wr_t            gnt_wr;
    logic               owner_empty;

    logic               dbg_en_q, dbg_en_d;
    logic [23:0]        dbg_addr_q, dbg_addr_d;
    logic [31:0]        dbg_data_q, dbg_data_d;
    logic               lock_active_q, lock_active_d;
    logic [OWNER_W-1:0] lock_owner_q, lock_owner_d;
    logic               lock_timeout_q, lock_timeout_d;
    logic               halted_q, halted_d;
    logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    for (genvar g = 0; g < NREQ; g++) begin : g_req
        dbg_wr_t wdata;

        assign wdata          = '{addr: req_addr_i[g], data: req_data_i[g]};
        // Ready depends only on registered state, never on valid.
        assign req_ready_o[g] = !fifo_full[g] && !halted_q;
        assign push[g]        = req_valid_i[g] && req_ready_o[g];
        assign eligible[g]    = !fifo_empty[g] && !halted_q &&
                                (!lock_active_q || (lock_owner_q == OWNER_W'(g)));

        debug_wr_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (push[g]),
            .wdata_i (wdata),
            .pop_i   (pop[g]),
            .head_o  (fifo_head[g]),
            .full_o  (fifo_full[g]),
            .empty_o (fifo_empty[g])
        );
    end

    // Pick the first eligible requester at or after the RR pointer; the smallest offset wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        gnt_wr    = '0;
        pop       = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            for (int j = 0; j < NREQ; j++) begin
                if (eligible[j] && (j == ((int'(rr_ptr_q) + off) % NREQ))) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = OWNER_W'(j);
                    gnt_wr    = fifo_head[j];
                    pop       = '0;
                    pop[j]    = 1'b1;
                end
            end
        end
    end

    // Whether the current lock owner has nothing queued (drives the idle timeout).
    always_comb begin
        owner_empty = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (lock_owner_q == OWNER_W'(j)) owner_empty = fifo_empty[j];
        end
    end

    // Output register, RR pointer, lock, timeout and halt next-state.
    always_comb begin
        dbg_en_d       = gnt_valid;
        dbg_addr_d     = dbg_addr_q;
        dbg_data_d     = dbg_data_q;
        lock_active_d  = lock_active_q;
        lock_owner_d   = lock_owner_q;
        lock_timeout_d = 1'b0;
        halted_d       = halted_q;
        rr_ptr_d       = rr_ptr_q;
        cnt_d          = cnt_q;

        if (gnt_valid) begin
            dbg_addr_d = gnt_wr.addr;
            dbg_data_d = gnt_wr.data;
            rr_ptr_d   = (gnt_idx == OWNER_W'(NREQ - 1)) ? '0 : gnt_idx + OWNER_W'(1);
            if (gnt_wr.addr == HALT_ADDR) halted_d = 1'b1;
            if (!lock_active_q && is_safe_body_addr(gnt_wr.addr)) begin
                lock_active_d = 1'b1;
                lock_owner_d  = gnt_idx;
            end else if (lock_active_q && (gnt_wr.addr == SAFE_COMMIT_ADDR)) begin
                // Only the owner is eligible while locked, so this is the owner's commit.
                lock_active_d = 1'b0;
            end
        end

        // Once halted the lock and its counter are frozen as they stand.
        if (!lock_active_q) begin
            cnt_d = '0;
        end else if (!halted_q) begin
            if (!owner_empty || gnt_valid) begin
                cnt_d = '0;
            end else if (cnt_q >= CNT_W'(LOCK_TIMEOUT - 1)) begin
                lock_active_d  = 1'b0;
                lock_timeout_d = 1'b1;
                cnt_d          = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // All arbiter state, cleared asynchronously by rst_ni.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dbg_en_q       <= 1'b0;
            dbg_addr_q     <= '0;
            dbg_data_q     <= '0;
            lock_active_q  <= 1'b0;
            lock_owner_q   <= '0;
            lock_timeout_q <= 1'b0;
            halted_q       <= 1'b0;
            rr_ptr_q       <= '0;
            cnt_q          <= '0;
        end else begin
            dbg_en_q       <= dbg_en_d;
            dbg_addr_q     <= dbg_addr_d;
            dbg_data_q     <= dbg_data_d;
            lock_active_q  <= lock_active_d;
            lock_owner_q   <= lock_owner_d;
            lock_timeout_q <= lock_timeout_d;
            halted_q       <= halted_d;
            rr_ptr_q       <= rr_ptr_d;
            cnt_q          <= cnt_d;
        end
    end

    assign dbg_en_o       = dbg_en_q;
    assign dbg_we_o       = dbg_en_q;
    assign dbg_addr_o     = dbg_addr_q;
    assign dbg_data_o     = dbg_data_q;
    assign lock_active_o  = lock_active_q;
    assign lock_owner_o   = lock_owner_q;
    assign lock_timeout_o = lock_timeout_q;
    assign halted_o       = halted_q;

endmodule

// File: tb/tb_debug_wr_arbiter.sv
// Bench for debug_wr_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based reference model.
module tb_debug_wr_arbiter;
    import debug_wr_arbiter_pkg::*;

    localparam int NREQ  = 2;
    localparam int DEPTH = 4;
    localparam int LT    = 8;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b1;
    logic [NREQ-1:0]       vld;
    logic [NREQ-1:0]       req_ready_o;
    logic [NREQ-1:0][23:0] addr_drv;
    logic [NREQ-1:0][31:0] data_drv;
    logic                  dbg_en_o, dbg_we_o;
    logic [23:0]           dbg_addr_o;
    logic [31:0]           dbg_data_o;
    logic                  lock_active_o;
    logic [0:0]            lock_owner_o;
    logic                  lock_timeout_o;
    logic                  halted_o;

    always #5 clk_i = ~clk_i;

    debug_wr_arbiter #(
        .NREQ         (NREQ),
        .FIFO_DEPTH   (DEPTH),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (vld),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (addr_drv),
        .req_data_i     (data_drv),
        .dbg_en_o       (dbg_en_o),
        .dbg_we_o       (dbg_we_o),
        .dbg_addr_o     (dbg_addr_o),
        .dbg_data_o     (dbg_data_o),
        .lock_active_o  (lock_active_o),
        .lock_owner_o   (lock_owner_o),
        .lock_timeout_o (lock_timeout_o),
        .halted_o       (halted_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    dbg_wr_t     mq [NREQ][$];
    int          m_rr;
    bit          m_locked;
    int          m_owner;
    bit          m_halted;
    int          m_idle;
    logic        m_en;
    logic [23:0] m_addr;
    logic [31:0] m_data;
    logic        m_to;

    logic [NREQ-1:0] acc;
    int              to_pulses;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) mq[i].delete();
        m_rr = 0; m_locked = 0; m_owner = 0; m_halted = 0; m_idle = 0;
        m_en = 0; m_addr = '0; m_data = '0; m_to = 0;
    endtask

    task automatic compare_outputs();
        logic [NREQ-1:0] mready;
        for (int i = 0; i < NREQ; i++) mready[i] = (mq[i].size() < DEPTH) && !m_halted;
        chk("ready",        64'(req_ready_o),    64'(mready));
        chk("dbg_en",       64'(dbg_en_o),       64'(m_en));
        chk("dbg_we",       64'(dbg_we_o),       64'(m_en));
        chk("dbg_addr",     64'(dbg_addr_o),     64'(m_addr));
        chk("dbg_data",     64'(dbg_data_o),     64'(m_data));
        chk("lock_active",  64'(lock_active_o),  64'(m_locked));
        chk("lock_owner",   64'(lock_owner_o),   64'(m_owner));
        chk("lock_timeout", 64'(lock_timeout_o), 64'(m_to));
        chk("halted",       64'(halted_o),       64'(m_halted));
    endtask

    // One clock: predict the edge from the rules, then compare after it.
    task automatic cycle();
        logic [NREQ-1:0] mready;
        int              g;
        int              j;
        dbg_wr_t         w;
        for (int i = 0; i < NREQ; i++) mready[i] = (mq[i].size() < DEPTH) && !m_halted;
        acc = vld & mready;
        g = -1;
        if (!m_halted) begin
            for (int off = 0; off < NREQ; off++) begin
                j = (m_rr + off) % NREQ;
                if (g < 0 && mq[j].size() > 0 && (!m_locked || m_owner == j)) g = j;
            end
        end
        m_to = 0;
        if (m_locked && !m_halted) begin
            if (mq[m_owner].size() == 0) begin
                m_idle++;
                if (m_idle == LT) begin
                    m_locked = 0; m_idle = 0; m_to = 1;
                end
            end else begin
                m_idle = 0;
            end
        end
        if (g >= 0) begin
            w = mq[g].pop_front();
            m_en = 1; m_addr = w.addr; m_data = w.data;
            m_rr = (g + 1) % NREQ;
            if (!m_locked && (w.addr == 24'h50 || w.addr == 24'h54 || w.addr == 24'h58)) begin
                m_locked = 1; m_owner = g; m_idle = 0;
            end else if (m_locked && w.addr == 24'h5C) begin
                m_locked = 0;
            end
            if (w.addr == 24'h04) m_halted = 1;
        end else begin
            m_en = 0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                w.addr = addr_drv[i];
                w.data = data_drv[i];
                mq[i].push_back(w);
            end
        end
        @(posedge clk_i);
        #1;
        if (lock_timeout_o) to_pulses++;
        compare_outputs();
    endtask

    // Asynchronous reset asserted mid-cycle, held over two edges.
    task automatic do_reset();
        vld = '0;
        #3;
        rst_ni = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        compare_outputs();
        rst_ni = 1'b1;
    endtask

    logic [23:0] pick_tab [7] = '{24'h00, 24'h08, 24'h10, 24'h50, 24'h54, 24'h58, 24'h5C};
    logic [23:0] safe_seq [4] = '{24'h50, 24'h54, 24'h58, 24'h5C};

    initial begin
        int n0, n1, lock_cycles, en_cycles, halt_age;
        vld = '0; addr_drv = '0; data_drv = '0;
        model_reset();
        do_reset();
        chk("rst_dbg_en", 64'(dbg_en_o), 64'(0));
        chk("rst_halted", 64'(halted_o), 64'(0));

        // Single write through an idle FIFO
        vld = 2'b01; addr_drv[0] = 24'h000000; data_drv[0] = 32'h41;
        cycle();
        chk("tp1_no_bypass", 64'(dbg_en_o), 64'(0));
        vld = '0;
        cycle();
        chk("tp1_en", 64'(dbg_en_o), 64'(1));
        chk("tp1_data", 64'(dbg_data_o), 64'(32'h41));
        cycle();
        chk("tp1_idle", 64'(dbg_en_o), 64'(0));
        repeat (2) cycle();

        // Fairness with both requesters streaming
        do_reset();
        n0 = 0; n1 = 0;
        vld = 2'b11;
        for (int k = 0; k < 12; k++) begin
            addr_drv[0] = 24'h08; data_drv[0] = 32'hA0 + n0;
            addr_drv[1] = 24'h08; data_drv[1] = 32'hB0 + n1;
            cycle();
            if (acc[0]) n0++;
            if (acc[1]) n1++;
            if (k >= 1) chk("tp2_nogap", 64'(dbg_en_o), 64'(1));
            if (k == 1) chk("tp2_first", 64'(dbg_data_o), 64'(32'hA0));
            if (k == 2) chk("tp2_second", 64'(dbg_data_o), 64'(32'hB0));
            if (k == 3) chk("tp2_third", 64'(dbg_data_o), 64'(32'hA1));
        end
        vld = '0;
        repeat (10) cycle();

        // Atomic safe record against competing traffic
        do_reset();
        lock_cycles = 0;
        vld = 2'b11;
        for (int k = 0; k < 4; k++) begin
            addr_drv[0] = safe_seq[k]; data_drv[0] = 32'h100 + k;
            addr_drv[1] = 24'h10;      data_drv[1] = 32'hC0 + k;
            cycle();
            if (lock_active_o) lock_cycles++;
        end
        vld = '0;
        repeat (12) begin
            cycle();
            if (lock_active_o) lock_cycles++;
        end
        chk("tp3_lock_span", 64'(lock_cycles), 64'(3));

        // Lock timeout with an idle owner
        do_reset();
        to_pulses = 0;
        vld = 2'b01; addr_drv[0] = 24'h50; data_drv[0] = 32'h77;
        cycle();
        vld = 2'b10; addr_drv[1] = 24'h10; data_drv[1] = 32'h88;
        cycle();
        chk("tp4_locked", 64'(lock_active_o), 64'(1));
        vld = '0;
        repeat (14) cycle();
        chk("tp4_pulses", 64'(to_pulses), 64'(1));
        chk("tp4_last_data", 64'(dbg_data_o), 64'(32'h88));

        // Halt blocks everything afterwards
        do_reset();
        en_cycles = 0;
        vld = 2'b10; addr_drv[1] = 24'h04; data_drv[1] = 32'h1;
        cycle();
        addr_drv[1] = 24'h00; data_drv[1] = 32'h2;
        cycle();
        if (dbg_en_o) en_cycles++;
        vld = 2'b11; addr_drv[0] = 24'h08; addr_drv[1] = 24'h08;
        repeat (6) begin
            cycle();
            if (dbg_en_o) en_cycles++;
        end
        chk("tp5_writes", 64'(en_cycles), 64'(1));
        chk("tp5_ready", 64'(req_ready_o), 64'(0));
        chk("tp5_halted", 64'(halted_o), 64'(1));
        do_reset();
        chk("tp5_cleared", 64'(halted_o), 64'(0));

        // Backpressure while another requester holds the lock
        do_reset();
        n0 = 0;
        vld = 2'b10; addr_drv[1] = 24'h50; data_drv[1] = 32'h5;
        cycle();
        vld = 2'b01; addr_drv[0] = 24'h08;
        repeat (6) begin
            data_drv[0] = 32'hD0 + n0;
            cycle();
            if (acc[0]) n0++;
        end
        chk("tp6_accepted", 64'(n0), 64'(4));
        chk("tp6_ready0", 64'(req_ready_o[0]), 64'(0));
        vld = '0;
        repeat (14) cycle();
        chk("tp6_last", 64'(dbg_data_o), 64'(32'hD3));

        // Random traffic, with one mid-operation reset and recovery from halts
        do_reset();
        halt_age = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                vld[i] = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 299) == 0)
                    addr_drv[i] = 24'h04;
                else if ($urandom_range(0, 3) == 0)
                    addr_drv[i] = 24'(32'h1000 + $urandom_range(0, 255) * 4);
                else
                    addr_drv[i] = pick_tab[$urandom_range(0, 6)];
                data_drv[i] = $urandom;
            end
            cycle();
            if (m_halted) halt_age++;
            if (c == 300 || halt_age > 10) begin
                halt_age = 0;
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
